// File: rtl/bcd_conv_pkg.sv
// Shared constants and types for the binary-to-BCD conversion scheduler.
//   DATA_W     : binary input width (fixed at 8)
//   STEPS      : shift-and-add-3 iterations per conversion
//   SCRATCH_W  : {hundreds, tens, ones, binary} working register width
//   *_LSB      : bit offsets of each digit field inside the scratch register
package bcd_conv_pkg;

  localparam int DATA_W    = 8;
  localparam int STEPS     = 8;
  localparam int ONES_W    = 4;
  localparam int TENS_W    = 4;
  localparam int HUND_W    = 2;
  localparam int SCRATCH_W = HUND_W + TENS_W + ONES_W + DATA_W;

  localparam int ONES_LSB  = DATA_W;
  localparam int TENS_LSB  = ONES_LSB + ONES_W;
  localparam int HUND_LSB  = TENS_LSB + TENS_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/bcd_conv_scheduler_dabble_step.sv
// One combinational shift-and-add-3 (double dabble) iteration.
//   scratch     : current {hundreds, tens, ones, binary} register
//   scratch_nxt : value after adjusting the ones/tens nibbles and shifting left 1
// The hundreds field tops out at 2 for 8-bit inputs, so it never needs adjusting.
module dabble_step
  import bcd_conv_pkg::*;
(
  input  logic [SCRATCH_W-1:0] scratch,
  output logic [SCRATCH_W-1:0] scratch_nxt
);

  // Digits entering this are 0..9, so the 4-bit sum never carries out.
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  logic [SCRATCH_W-1:0] adj;

  always_comb begin
    adj                      = scratch;
    adj[ONES_LSB +: ONES_W]  = add3(scratch[ONES_LSB +: ONES_W]);
    adj[TENS_LSB +: TENS_W]  = add3(scratch[TENS_LSB +: TENS_W]);
    scratch_nxt              = {adj[SCRATCH_W-2:0], 1'b0};
  end

endmodule

// File: rtl/bcd_conv_scheduler.sv
// Round-robin scheduler sharing one iterative binary-to-BCD converter.
//   clk, rst_n : clock and asynchronous active-low reset
//   req        : per-requester request
//   data       : requester i value at data[i*DATA_W +: DATA_W]
//   gnt        : one-cycle one-hot pulse when requester i's value is captured
//   busy       : high from capture until the result handshake completes
//   valid/ready: result handshake; id/ones/tens/hundreds hold the result
module bcd_conv_scheduler
  import bcd_conv_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int DATA_W = bcd_conv_pkg::DATA_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] data,
  output logic [N_REQ-1:0]        gnt,
  output logic                    busy,
  output logic                    valid,
  input  logic                    ready,
  output logic [1:0]              id,
  output logic [ONES_W-1:0]       ones,
  output logic [TENS_W-1:0]       tens,
  output logic [HUND_W-1:0]       hundreds
);

  localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

  state_e               state_q, state_d;
  logic [1:0]           ptr_q;        // index with top priority in the next arbitration
  logic [1:0]           win_q;
  logic [2:0]           cnt_q;
  logic [SCRATCH_W-1:0] scratch_q, scratch_nxt;

  logic                 found;
  logic [1:0]           win_idx;
  logic [DATA_W-1:0]    win_data;
  logic [N_REQ-1:0]     gnt_d;
  logic                 capture, last_step, accept;

  dabble_step u_step (
    .scratch     (scratch_q),
    .scratch_nxt (scratch_nxt)
  );

  // Round-robin pick: walk priorities starting at ptr_q, first active request wins.
  always_comb begin
    found    = 1'b0;
    win_idx  = '0;
    win_data = '0;
    gnt_d    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && req[i] && (i == (int'(ptr_q) + k) % N_REQ)) begin
          found    = 1'b1;
          win_idx  = 2'(i);
          win_data = data[i*DATA_W +: DATA_W];
          gnt_d[i] = 1'b1;
        end
      end
    end
  end

  assign capture   = (state_q == IDLE) && found;
  assign last_step = (state_q == SHIFT) && (cnt_q == LAST_STEP);
  assign accept    = (state_q == DONE) && ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (capture)   state_d = SHIFT;
      SHIFT:   if (last_step) state_d = DONE;
      DONE:    if (accept)    state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Capture -> eight dabble steps -> hold result until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt       <= '0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      id        <= '0;
      ones      <= '0;
      tens      <= '0;
      hundreds  <= '0;
      ptr_q     <= '0;
      win_q     <= '0;
      cnt_q     <= '0;
      scratch_q <= '0;
    end else begin
      gnt <= '0;
      if (capture) begin
        gnt       <= gnt_d;
        busy      <= 1'b1;
        cnt_q     <= '0;
        win_q     <= win_idx;
        scratch_q <= {{(SCRATCH_W-DATA_W){1'b0}}, win_data};
        ptr_q     <= (win_idx == 2'(N_REQ - 1)) ? 2'd0 : win_idx + 2'd1;
      end
      if (state_q == SHIFT) begin
        scratch_q <= scratch_nxt;
        cnt_q     <= cnt_q + 3'd1;
        if (last_step) begin
          ones     <= scratch_nxt[ONES_LSB +: ONES_W];
          tens     <= scratch_nxt[TENS_LSB +: TENS_W];
          hundreds <= scratch_nxt[HUND_LSB +: HUND_W];
          id       <= win_q;
          valid    <= 1'b1;
        end
      end
      if (accept) begin
        valid <= 1'b0;
        busy  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bcd_conv_scheduler.sv
module tb_bcd_conv_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req;
  logic [15:0] data;
  logic [1:0]  gnt;
  logic        busy, valid, ready;
  logic [1:0]  id;
  logic [3:0]  ones, tens;
  logic [1:0]  hundreds;

  int errors = 0;
  int checks = 0;

  bcd_conv_scheduler #(.N_REQ(2), .DATA_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .data     (data),
    .gnt      (gnt),
    .busy     (busy),
    .valid    (valid),
    .ready    (ready),
    .id       (id),
    .ones     (ones),
    .tens     (tens),
    .hundreds (hundreds)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0] rq;
    logic [7:0] val;
    int         eid, eh, et, eo;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Waits for the grant, then the result, checks both and completes the handshake.
  task automatic expect_one(input logic [1:0] eg, input int eid, input int eh,
                            input int et, input int eo, input bit drop);
    int n;
    n = 0;
    while (gnt == 2'b00 && n < 20) begin @(negedge clk); n++; end
    check("gnt", 32'(gnt), 32'(eg));
    check("busy_set", 32'(busy), 1);
    if (drop) req = 2'b00;
    @(negedge clk);
    check("gnt_pulse", 32'(gnt), 0);
    n = 1;
    while (!valid && n < 20) begin @(negedge clk); n++; end
    check("latency", n, 8);
    check("id", 32'(id), eid);
    check("hundreds", 32'(hundreds), eh);
    check("tens", 32'(tens), et);
    check("ones", 32'(ones), eo);
    @(negedge clk);
    check("valid_clr", 32'(valid), 0);
    check("busy_clr", 32'(busy), 0);
  endtask

  task automatic convert(input logic [1:0] rq, input logic [7:0] val, input int eid,
                         input int eh, input int et, input int eo);
    if (rq[0]) data[7:0] = val;
    else       data[15:8] = val;
    req = rq;
    expect_one(rq, eid, eh, et, eo, 1'b1);
  endtask

  initial begin
    int vcnt;
    logic [7:0] v8;

    tbl[0] = '{2'b01, 8'd255, 0, 2, 5, 5};
    tbl[1] = '{2'b01, 8'd0,   0, 0, 0, 0};
    tbl[2] = '{2'b01, 8'd100, 0, 1, 0, 0};
    tbl[3] = '{2'b01, 8'd99,  0, 0, 9, 9};
    tbl[4] = '{2'b10, 8'd9,   1, 0, 0, 9};
    tbl[5] = '{2'b10, 8'd10,  1, 0, 1, 0};
    tbl[6] = '{2'b10, 8'd199, 1, 1, 9, 9};
    tbl[7] = '{2'b01, 8'd128, 0, 1, 2, 8};

    rst_n = 1'b0; req = 2'b00; data = '0; ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(gnt), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_id", 32'(id), 0);
    check("rst_digits", {26'd0, hundreds, tens, ones}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Both requesting after reset: 0 first, then rotate to 1, then back to 0.
    data = {8'd34, 8'd12};
    req  = 2'b11;
    expect_one(2'b01, 0, 0, 1, 2, 1'b0);
    expect_one(2'b10, 1, 0, 3, 4, 1'b0);
    expect_one(2'b01, 0, 0, 1, 2, 1'b0);
    req = 2'b00;
    @(negedge clk);

    for (int i = 0; i < 8; i++)
      convert(tbl[i].rq, tbl[i].val, tbl[i].eid, tbl[i].eh, tbl[i].et, tbl[i].eo);

    // Back-pressure: result and busy held, new requests ignored.
    ready = 1'b0;
    data[7:0] = 8'd73;
    req = 2'b01;
    vcnt = 0;
    while (gnt == 2'b00 && vcnt < 20) begin @(negedge clk); vcnt++; end
    check("bp_gnt", 32'(gnt), 1);
    req = 2'b00;
    vcnt = 0;
    while (!valid && vcnt < 20) begin @(negedge clk); vcnt++; end
    req = 2'b11;
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", 32'(valid), 1);
      check("bp_busy", 32'(busy), 1);
      check("bp_gnt_idle", 32'(gnt), 0);
      check("bp_result", {22'd0, id, hundreds, tens, ones}, {22'd0, 2'd0, 2'd0, 4'd7, 4'd3});
      @(negedge clk);
    end
    ready = 1'b1;
    @(negedge clk);
    check("bp_valid_clr", 32'(valid), 0);
    req = 2'b00;
    @(negedge clk);

    // Reset in the middle of a conversion.
    data[15:8] = 8'd200;
    req = 2'b10;
    vcnt = 0;
    while (gnt == 2'b00 && vcnt < 20) begin @(negedge clk); vcnt++; end
    check("mid_gnt", 32'(gnt), 2);
    req = 2'b00;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_valid", 32'(valid), 0);
    check("mid_rst_gnt", 32'(gnt), 0);
    check("mid_rst_id", 32'(id), 0);
    check("mid_rst_digits", {26'd0, hundreds, tens, ones}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    vcnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (valid || busy) vcnt++;
    end
    check("mid_no_result", vcnt, 0);
    data = {8'd200, 8'd5};
    req = 2'b11;
    expect_one(2'b01, 0, 0, 0, 5, 1'b0);
    req = 2'b00;
    convert(2'b10, 8'd200, 1, 2, 0, 0);

    // Every input value, alternating requesters, against arithmetic reference.
    for (int v = 0; v < 256; v++) begin
      v8 = 8'(v);
      convert(v8[0] ? 2'b10 : 2'b01, v8, v % 2, v / 100, (v / 10) % 10, v % 10);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
